text_console_ctrl: RTL and testbench

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_pkg.sv | 22 ++
 rtl/text_console_ctrl.sv | 143 ++++++++++++++
 tb/tb_text_console_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console controller: register map,
// STATUS bit positions, default screen geometry and the controller FSM states.
package text_console_pkg;

    localparam logic [11:0] ADDR_DATA   = 12'h081;
    localparam logic [11:0] ADDR_COL    = 12'h082;
    localparam logic [11:0] ADDR_ROW    = 12'h083;
    localparam logic [11:0] ADDR_STATUS = 12'h084;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DROP_BIT  = 1;
    localparam int STATUS_CLEAR_BIT = 2;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/text_console_ctrl.sv
// Memory-mapped text console: tracks a cursor, turns CPU character writes into
// text-RAM writes and can sweep the whole screen with a fill character.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int         COLS      = DEFAULT_COLS,
    parameter int         ROWS      = DEFAULT_ROWS,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic [11:0] address,
    input  logic        io_w_en,
    input  logic        io_r_en,
    output logic [7:0]  dout,
    output logic [7:0]  v_din,
    output logic [11:0] v_address,
    output logic        v_w_en
);

    localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
    localparam logic [7:0]  ROW_MAX   = 8'(ROWS - 1);
    localparam logic [11:0] FILL_LAST = 12'(COLS * ROWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  col_q, row_q;
    logic [7:0]  col_inc, row_inc;
    logic        drop_q;
    logic [11:0] fill_q;
    logic        print_we_q;
    logic [7:0]  print_din_q;
    logic [11:0] print_addr_q;
    logic [11:0] row_base, cur_addr;
    logic [7:0]  status_val;
    logic        busy;
    logic        wr_data, wr_col, wr_row, wr_status, clear_req, printable;

    assign busy      = (state_q == ST_CLEAR);
    assign wr_data   = io_w_en && (address == ADDR_DATA);
    assign wr_col    = io_w_en && (address == ADDR_COL);
    assign wr_row    = io_w_en && (address == ADDR_ROW);
    assign wr_status = io_w_en && (address == ADDR_STATUS);
    assign clear_req = wr_status && din[STATUS_CLEAR_BIT] && !busy;
    assign printable = (din >= 8'h20) && (din <= 8'h7E);

    // Row base address; the 80-column screen uses a shift-add instead of a multiplier.
    generate
        if (COLS == 80) begin : g_mul80
            assign row_base = ({4'd0, row_q} << 6) + ({4'd0, row_q} << 4);
        end else begin : g_mul
            assign row_base = 12'({4'd0, row_q} * COLS);
        end
    endgenerate

    assign cur_addr = row_base + {4'd0, col_q};
    assign col_inc  = (col_q == COL_MAX) ? 8'd0 : col_q + 8'd1;
    assign row_inc  = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;

    always_comb begin
        status_val                  = 8'd0;
        status_val[STATUS_BUSY_BIT] = busy;
        status_val[STATUS_DROP_BIT] = drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_req) state_d = ST_CLEAR;
            ST_CLEAR: if (fill_q == FILL_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= 8'd0;
            row_q        <= 8'd0;
            drop_q       <= 1'b0;
            fill_q       <= 12'd0;
            print_we_q   <= 1'b0;
            print_din_q  <= 8'd0;
            print_addr_q <= 12'd0;
            dout         <= 8'd0;
        end else begin
            print_we_q <= 1'b0;

            if (busy) begin
                fill_q <= (fill_q == FILL_LAST) ? 12'd0 : fill_q + 12'd1;
                if (wr_data || wr_col || wr_row) drop_q <= 1'b1;
            end

            if (wr_status && din[STATUS_DROP_BIT]) drop_q <= 1'b0;

            if (clear_req) begin
                col_q  <= 8'd0;
                row_q  <= 8'd0;
                fill_q <= 12'd0;
            end

            if (!busy) begin
                if (wr_data) begin
                    if (printable) begin
                        print_we_q   <= 1'b1;
                        print_din_q  <= din;
                        print_addr_q <= cur_addr;
                        col_q        <= col_inc;
                        if (col_q == COL_MAX) row_q <= row_inc;
                    end else if (din == 8'h0D) begin
                        col_q <= 8'd0;
                    end else if (din == 8'h0A) begin
                        row_q <= row_inc;
                    end else if (din == 8'h08) begin
                        if (col_q != 8'd0) col_q <= col_q - 8'd1;
                    end
                end
                if (wr_col) col_q <= (din > COL_MAX) ? COL_MAX : din;
                if (wr_row) row_q <= (din > ROW_MAX) ? ROW_MAX : din;
            end

            // DATA is write-only and reads back as zero; unmapped reads leave dout alone.
            if (io_r_en) begin
                case (address)
                    ADDR_DATA:   dout <= 8'd0;
                    ADDR_COL:    dout <= col_q;
                    ADDR_ROW:    dout <= row_q;
                    ADDR_STATUS: dout <= status_val;
                    default:     dout <= dout;
                endcase
            end
        end
    end

    assign v_w_en    = print_we_q || busy;
    assign v_din     = busy ? FILL_CHAR : print_din_q;
    assign v_address = busy ? fill_q : print_addr_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: cursor writes, control characters,
// screen clear sweep, drop flag handling and reset during a clear.
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'd0;
    logic [11:0] address = 12'd0;
    logic        io_w_en = 1'b0;
    logic        io_r_en = 1'b0;
    logic [7:0]  dout;
    logic [7:0]  v_din;
    logic [11:0] v_address;
    logic        v_w_en;

    int checks = 0;
    int failures = 0;

    int          wr_count = 0;
    logic [11:0] last_addr = 12'd0;
    logic [7:0]  last_din = 8'd0;
    logic        chk_fill = 1'b0;
    int          exp_fill = 0;
    int          fill_err = 0;
    int          gap_err = 0;

    text_console_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .address   (address),
        .io_w_en   (io_w_en),
        .io_r_en   (io_r_en),
        .dout      (dout),
        .v_din     (v_din),
        .v_address (v_address),
        .v_w_en    (v_w_en)
    );

    always #5 clk = ~clk;

    // Records every RAM write and checks that a clear sweep is gap-free and in order.
    always @(negedge clk) begin
        if (v_w_en) begin
            wr_count  = wr_count + 1;
            last_addr = v_address;
            last_din  = v_din;
            if (chk_fill) begin
                if (v_address != 12'(exp_fill) || v_din != 8'h20) fill_err = fill_err + 1;
                exp_fill = exp_fill + 1;
            end
        end else if (chk_fill && exp_fill > 0 && exp_fill < 2400) begin
            gap_err = gap_err + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        address = addr;
        din     = data;
        io_w_en = 1'b1;
        @(posedge clk); #1;
        io_w_en = 1'b0;
    endtask

    task automatic readReg(input logic [11:0] addr, output logic [7:0] data);
        @(posedge clk); #1;
        address = addr;
        io_r_en = 1'b1;
        @(posedge clk); #1;
        io_r_en = 1'b0;
        data = dout;
    endtask

    task automatic startFillCheck();
        exp_fill = 0;
        fill_err = 0;
        gap_err  = 0;
        chk_fill = 1'b1;
    endtask

    task automatic waitWrites(input int base, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_count - base >= target) break;
        end
    endtask

    initial begin
        logic [7:0] rd;
        int base;
        int found;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout", {24'd0, dout}, 32'h0);
        checkOutput("reset_vwen", {31'd0, v_w_en}, 32'h0);
        rst = 1'b0;
        readReg(12'h082, rd); checkOutput("reset_col", {24'd0, rd}, 32'd0);
        readReg(12'h083, rd); checkOutput("reset_row", {24'd0, rd}, 32'd0);
        readReg(12'h084, rd); checkOutput("reset_status", {24'd0, rd}, 32'h00);

        // Single character at col 5, row 2
        applyStimulus(12'h082, 8'd5);
        applyStimulus(12'h083, 8'd2);
        base = wr_count;
        applyStimulus(12'h081, 8'h41);
        checkOutput("print_we_n1", {31'd0, v_w_en}, 32'h1);
        @(posedge clk); #1;
        checkOutput("print_we_n2", {31'd0, v_w_en}, 32'h0);
        checkOutput("print_count", 32'(wr_count - base), 32'd1);
        checkOutput("print_addr", {20'd0, last_addr}, 32'd165);
        checkOutput("print_din", {24'd0, last_din}, 32'h41);
        readReg(12'h082, rd); checkOutput("print_col_after", {24'd0, rd}, 32'd6);
        readReg(12'h081, rd); checkOutput("data_reads_zero", {24'd0, rd}, 32'd0);

        // Last cell wraps cursor back to origin
        applyStimulus(12'h082, 8'd79);
        applyStimulus(12'h083, 8'd29);
        base = wr_count;
        applyStimulus(12'h081, 8'h42);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("last_count", 32'(wr_count - base), 32'd1);
        checkOutput("last_addr", {20'd0, last_addr}, 32'd2399);
        checkOutput("last_din", {24'd0, last_din}, 32'h42);
        readReg(12'h082, rd); checkOutput("wrap_col", {24'd0, rd}, 32'd0);
        readReg(12'h083, rd); checkOutput("wrap_row", {24'd0, rd}, 32'd0);

        // Control characters, discarded values and clamping
        base = wr_count;
        applyStimulus(12'h082, 8'd0);
        applyStimulus(12'h081, 8'h08);
        readReg(12'h082, rd); checkOutput("bs_at_zero", {24'd0, rd}, 32'd0);
        applyStimulus(12'h082, 8'd3);
        applyStimulus(12'h081, 8'h08);
        readReg(12'h082, rd); checkOutput("bs_at_three", {24'd0, rd}, 32'd2);
        applyStimulus(12'h081, 8'h7F);
        readReg(12'h082, rd); checkOutput("discard_col", {24'd0, rd}, 32'd2);
        applyStimulus(12'h082, 8'd10);
        applyStimulus(12'h081, 8'h0D);
        readReg(12'h082, rd); checkOutput("cr_col", {24'd0, rd}, 32'd0);
        applyStimulus(12'h083, 8'd29);
        applyStimulus(12'h081, 8'h0A);
        readReg(12'h083, rd); checkOutput("lf_wrap_row", {24'd0, rd}, 32'd0);
        applyStimulus(12'h083, 8'd4);
        applyStimulus(12'h081, 8'h0A);
        readReg(12'h083, rd); checkOutput("lf_row", {24'd0, rd}, 32'd5);
        applyStimulus(12'h082, 8'd200);
        readReg(12'h082, rd); checkOutput("col_clamp", {24'd0, rd}, 32'd79);
        applyStimulus(12'h083, 8'd200);
        readReg(12'h083, rd); checkOutput("row_clamp", {24'd0, rd}, 32'd29);
        checkOutput("ctrl_no_writes", 32'(wr_count - base), 32'd0);

        // Full clear sweep
        applyStimulus(12'h082, 8'd7);
        applyStimulus(12'h083, 8'd4);
        startFillCheck();
        base = wr_count;
        applyStimulus(12'h084, 8'h04);
        readReg(12'h084, rd); checkOutput("clear_busy", {24'd0, rd}, 32'h01);
        waitWrites(base, 2400, 2600);
        repeat (4) @(posedge clk);
        #1;
        chk_fill = 1'b0;
        checkOutput("clear_count", 32'(wr_count - base), 32'd2400);
        checkOutput("clear_seq_err", 32'(fill_err), 32'd0);
        checkOutput("clear_gap_err", 32'(gap_err), 32'd0);
        checkOutput("clear_last_addr", {20'd0, last_addr}, 32'd2399);
        checkOutput("clear_vwen_off", {31'd0, v_w_en}, 32'h0);
        readReg(12'h084, rd); checkOutput("clear_done_status", {24'd0, rd}, 32'h00);
        readReg(12'h082, rd); checkOutput("clear_col", {24'd0, rd}, 32'd0);
        readReg(12'h083, rd); checkOutput("clear_row", {24'd0, rd}, 32'd0);

        // Writes while busy are dropped and flagged
        startFillCheck();
        base = wr_count;
        applyStimulus(12'h084, 8'h04);
        applyStimulus(12'h081, 8'h41);
        applyStimulus(12'h082, 8'd5);
        applyStimulus(12'h084, 8'h04);
        readReg(12'h084, rd); checkOutput("drop_busy_status", {24'd0, rd}, 32'h03);
        waitWrites(base, 2400, 2600);
        repeat (4) @(posedge clk);
        #1;
        chk_fill = 1'b0;
        checkOutput("drop_count", 32'(wr_count - base), 32'd2400);
        checkOutput("drop_seq_err", 32'(fill_err), 32'd0);
        readReg(12'h082, rd); checkOutput("drop_col_ignored", {24'd0, rd}, 32'd0);
        readReg(12'h084, rd); checkOutput("drop_sticky", {24'd0, rd}, 32'h02);
        applyStimulus(12'h084, 8'h02);
        readReg(12'h084, rd); checkOutput("drop_cleared", {24'd0, rd}, 32'h00);

        // Set drop again, then clear it and start a clear in one write
        base = wr_count;
        applyStimulus(12'h084, 8'h04);
        applyStimulus(12'h083, 8'd3);
        waitWrites(base, 2400, 2600);
        repeat (4) @(posedge clk);
        readReg(12'h084, rd); checkOutput("drop_set_again", {24'd0, rd}, 32'h02);
        startFillCheck();
        applyStimulus(12'h084, 8'h06);
        readReg(12'h084, rd); checkOutput("combo_status", {24'd0, rd}, 32'h01);

        // Reset in the middle of a clear
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (v_w_en && v_address == 12'd100) begin
                found = 1;
                break;
            end
        end
        checkOutput("found_fill_100", 32'(found), 32'd1);
        chk_fill = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_vwen", {31'd0, v_w_en}, 32'h0);
        checkOutput("rst_dout", {24'd0, dout}, 32'h0);
        rst = 1'b0;
        base = wr_count;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("rst_no_more_writes", 32'(wr_count - base), 32'd0);
        readReg(12'h084, rd); checkOutput("rst_status", {24'd0, rd}, 32'h00);
        readReg(12'h082, rd); checkOutput("rst_col", {24'd0, rd}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
